// File: rtl/fifo_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// fifo_rr_scheduler_if
//   Shared output stream of the round-robin FIFO scheduler.
//
//   Signals
//     data_o   word taken from the granted FIFO
//     ch_o     index of the channel that sourced data_o
//     valid_o  data_o / ch_o / last_o are meaningful this cycle
//     ready_i  downstream consumer accepts the word this cycle
//     last_o   word closes a full-quota burst
//
//   Modports
//     master   scheduler side (drives the word, samples ready)
//     slave    consumer side (samples the word, drives ready)
// ---------------------------------------------------------------------------
interface fifo_rr_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2
);

  logic [DATA_WIDTH-1:0] data_o;
  logic [CH_WIDTH-1:0]   ch_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;

  modport master (
    output data_o,
    output ch_o,
    output valid_o,
    output last_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  ch_o,
    input  valid_o,
    input  last_o,
    output ready_i
  );

endinterface : fifo_rr_scheduler_if

// File: rtl/fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_rr_scheduler
//   Drains CH_AMOUNT first-word-fall-through FIFOs onto one valid/ready
//   stream. Channels are granted round-robin. Each grant may move up to
//   BURST_LEN words, and every word is tagged with its source channel.
//
//   Ports
//     clk_i         clock
//     rst_i         asynchronous, active-high reset
//     ch_mask_i     per-channel eligibility, looked at only while idle
//     fifo_empty_i  empty flag of each FIFO
//     fifo_data_i   head word of each FIFO, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//     fifo_rd_o     read strobe of each FIFO (one-hot or zero)
//     busy_o        a grant is active
//     out_if        output stream (data_o, ch_o, valid_o, ready_i, last_o)
// ---------------------------------------------------------------------------
module fifo_rr_scheduler #(
  parameter int CH_AMOUNT  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CH_WIDTH   = $clog2(CH_AMOUNT),
  parameter int CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CH_AMOUNT-1:0]            ch_mask_i,
  input  logic [CH_AMOUNT-1:0]            fifo_empty_i,
  input  logic [CH_AMOUNT*DATA_WIDTH-1:0] fifo_data_i,
  output logic [CH_AMOUNT-1:0]            fifo_rd_o,
  output logic                            busy_o,
  fifo_rr_scheduler_if.master             out_if
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered state
  state_t               state_r;
  logic [CH_WIDTH-1:0]  grant_r;   // channel owning the current grant
  logic [CH_WIDTH-1:0]  ch_r;      // registered copy of the winner for ch_o
  logic [CH_WIDTH-1:0]  ptr_r;     // last channel served; search starts after it
  logic [CNT_WIDTH-1:0] cnt_r;     // words moved in the current grant
  logic                 busy_r;

  // Combinational helpers
  logic [CH_AMOUNT-1:0]  req_s;
  logic [CH_WIDTH-1:0]   cand_s;
  logic [CH_WIDTH-1:0]   win_s;
  logic                  win_found_s;
  logic                  in_grant_s;
  logic                  valid_s;
  logic                  xfer_s;
  logic                  last_s;
  logic                  head_empty_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [CH_AMOUNT-1:0]  rd_s;
  logic [DATA_WIDTH-1:0] ch_data_s [CH_AMOUNT];

  // Unpack the flat FIFO data bus into one word per channel.
  for (genvar k = 0; k < CH_AMOUNT; k++) begin : g_unpack
    assign ch_data_s[k] = fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: start one past the last-served channel, with wrap,
  // so the channel just served has the lowest priority.
  always_comb begin
    req_s       = ~fifo_empty_i & ch_mask_i;
    cand_s      = {CH_WIDTH{1'b0}};
    win_s       = {CH_WIDTH{1'b0}};
    win_found_s = 1'b0;
    for (int i = 1; i <= CH_AMOUNT; i++) begin
      cand_s = CH_WIDTH'((int'(ptr_r) + i) % CH_AMOUNT);
      if (!win_found_s && req_s[cand_s]) begin
        win_found_s = 1'b1;
        win_s       = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Stream handshake of the granted channel. Valid follows the FIFO's empty
  // flag directly, so a word appears the cycle the FIFO presents it.
  always_comb begin
    in_grant_s   = (state_r == ST_GRANT);
    head_empty_s = fifo_empty_i[grant_r];
    valid_s      = in_grant_s & ~head_empty_s;
    xfer_s       = valid_s & out_if.ready_i;
    last_s       = valid_s & (cnt_r == CNT_WIDTH'(BURST_LEN - 1));
    if (in_grant_s) begin
      data_s = ch_data_s[grant_r];
    end else begin
      data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Read strobe goes only to the granted FIFO and only on an accepted word,
  // which keeps fifo_rd_o one-hot or zero and never reads an empty FIFO.
  always_comb begin
    rd_s = {CH_AMOUNT{1'b0}};
    for (int k = 0; k < CH_AMOUNT; k++) begin
      if (xfer_s && (grant_r == CH_WIDTH'(k))) begin
        rd_s[k] = 1'b1;
      end else begin
        rd_s[k] = 1'b0;
      end
    end
  end

  // Scheduler FSM: arbitrate in IDLE, then stream from the winner until the
  // quota is met or its FIFO runs dry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      grant_r <= {CH_WIDTH{1'b0}};
      ch_r    <= {CH_WIDTH{1'b0}};
      ptr_r   <= CH_WIDTH'(CH_AMOUNT - 1);
      cnt_r   <= {CNT_WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            grant_r <= win_s;
            ch_r    <= win_s;
            cnt_r   <= {CNT_WIDTH{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_GRANT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (head_empty_s) begin
            // Early release: the FIFO ran dry before the quota was used.
            ptr_r   <= grant_r;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (xfer_s) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            if (last_s) begin
              ptr_r   <= grant_r;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              busy_r  <= 1'b1;
            end
          end else begin
            // Backpressure: hold everything, no timeout.
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_o      = rd_s;
  assign busy_o         = busy_r;
  assign out_if.data_o  = data_s;
  assign out_if.ch_o    = ch_r;
  assign out_if.valid_o = valid_s;
  assign out_if.last_o  = last_s;

endmodule : fifo_rr_scheduler

// File: tb/tb_fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_scheduler
//   Directed bench for fifo_rr_scheduler (CH_AMOUNT=4, DATA_WIDTH=8,
//   BURST_LEN=4). Four behavioural FIFOs feed the DUT; every word the bench
//   expects on the stream is queued in a scoreboard and checked when the DUT
//   hands it over.
// ---------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  mask;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  fifo_rd;
  logic        busy;

  fifo_rr_scheduler_if #(.DATA_WIDTH(8), .CH_WIDTH(2)) sif ();

  fifo_rr_scheduler #(
    .CH_AMOUNT (4),
    .DATA_WIDTH(8),
    .BURST_LEN (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ch_mask_i   (mask),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_rd_o   (fifo_rd),
    .busy_o      (busy),
    .out_if      (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  exp_t       sb [$];

  int tests = 0;
  int fails = 0;

  // Values sampled at the last falling edge
  logic       s_valid, s_last, s_busy;
  logic [7:0] s_data;
  logic [1:0] s_ch;
  logic [3:0] s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      3: return q3[0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      fifo_empty[k]        = (qsize(k) == 0);
      fifo_data[k*8 +: 8]  = (qsize(k) == 0) ? 8'h00 : qfront(k);
    end
  endtask

  task automatic push_word(input int k, input logic [7:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      3: q3.push_back(d);
      default: ;
    endcase
    refresh();
  endtask

  task automatic pop_word(input int k);
    case (k)
      0: if (q0.size() > 0) void'(q0.pop_front());
      1: if (q1.size() > 0) void'(q1.pop_front());
      2: if (q2.size() > 0) void'(q2.pop_front());
      3: if (q3.size() > 0) void'(q3.pop_front());
      default: ;
    endcase
  endtask

  task automatic expect_word(input int ch, input logic [7:0] d, input logic last);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = d;
    e.last = last;
    sb.push_back(e);
  endtask

  // One clock: sample and check at the falling edge, then model the FIFO
  // reads just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_valid = sif.valid_o;
    s_data  = sif.data_o;
    s_ch    = sif.ch_o;
    s_last  = sif.last_o;
    s_busy  = busy;
    s_rd    = fifo_rd;
    chk("rd_onehot0", 32'($onehot0(s_rd)), 32'(1'b1));
    chk("rd_of_empty", 32'(s_rd & fifo_empty), 32'(4'h0));
    chk("rd_handshake", 32'(s_rd),
        (s_valid && sif.ready_i) ? (32'(1) << s_ch) : 32'(0));
    chk("valid_without_busy", 32'(s_valid & ~s_busy), 32'(1'b0));
    if (s_valid && sif.ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'(1));
      end else begin
        e = sb.pop_front();
        chk("word_data", 32'(s_data), 32'(e.data));
        chk("word_ch",   32'(s_ch),   32'(e.ch));
        chk("word_last", 32'(s_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (s_rd[k]) pop_word(k);
    end
    refresh();
  endtask

  task automatic run_until(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle();
      if (sb.size() == 0 && fifo_empty == 4'hF && !s_busy) done = 1'b1;
    end
    chk({tag, "_complete"}, 32'(done), 32'(1'b1));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(sif.valid_o), 32'(1'b0));
    chk({tag, "_busy"},  32'(busy),        32'(1'b0));
    chk({tag, "_rd"},    32'(fifo_rd),     32'(4'h0));
    chk({tag, "_data"},  32'(sif.data_o),  32'(8'h00));
    chk({tag, "_ch"},    32'(sif.ch_o),    32'(2'd0));
    chk({tag, "_last"},  32'(sif.last_o),  32'(1'b0));
  endtask

  initial begin
    logic [9:0] vpat;
    logic [9:0] bpat;
    logic [8:0] rpat;
    logic       pv, pr;
    logic [7:0] pd;

    rst         = 1'b1;
    mask        = 4'hF;
    sif.ready_i = 1'b1;
    fifo_empty  = 4'hF;
    fifo_data   = 32'h0;
    refresh();

    // Reset state
    cycle();
    cycle();
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single channel: FIFO1 holds A0..A5
    for (int i = 0; i < 6; i++) begin
      push_word(1, 8'(8'hA0 + i));
      expect_word(1, 8'(8'hA0 + i), (i == 3));
    end
    vpat = 10'b00_1101_1110;
    bpat = 10'b01_1101_1110;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("single_valid", 32'(s_valid), 32'(vpat[i]));
      chk("single_busy",  32'(s_busy),  32'(bpat[i]));
    end
    chk("single_sb_empty", 32'(sb.size()), 32'(0));
    chk("single_fifo1_drained", 32'(qsize(1)), 32'(0));

    // Re-reset so channel 0 has first priority again
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Round-robin fairness: all FIFOs hold 8 words
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) push_word(k, 8'(k*16 + i));
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        for (int w = 0; w < 4; w++) expect_word(k, 8'(k*16 + b*4 + w), (w == 3));
      end
    end
    run_until(200, "fair");
    for (int k = 0; k < 4; k++) chk("fair_drained", 32'(qsize(k)), 32'(0));

    // Wrap: last grant was 3, FIFOs 0 and 3 both nonempty
    push_word(0, 8'h70);
    push_word(0, 8'h71);
    push_word(3, 8'h80);
    push_word(3, 8'h81);
    expect_word(0, 8'h70, 1'b0);
    expect_word(0, 8'h71, 1'b0);
    expect_word(3, 8'h80, 1'b0);
    expect_word(3, 8'h81, 1'b0);
    run_until(40, "wrap");

    // Backpressure on a burst from FIFO2
    for (int i = 0; i < 4; i++) begin
      push_word(2, 8'(8'h20 + i));
      expect_word(2, 8'(8'h20 + i), (i == 3));
    end
    rpat = 9'b1_1111_0011;
    pv = 1'b0;
    pr = 1'b1;
    pd = 8'h00;
    for (int i = 0; i < 9; i++) begin
      sif.ready_i = rpat[i];
      cycle();
      if (pv && !pr) begin
        chk("bp_hold_valid", 32'(s_valid), 32'(1'b1));
        chk("bp_hold_data",  32'(s_data),  32'(pd));
        chk("bp_hold_ch",    32'(s_ch),    32'(2'd2));
      end
      chk("bp_rd_only_when_ready", 32'(s_rd[2] & ~rpat[i]), 32'(1'b0));
      pv = s_valid;
      pr = rpat[i];
      pd = s_data;
    end
    sif.ready_i = 1'b1;
    run_until(20, "bp");

    // Mask: only channel 1 eligible while FIFOs 0 and 1 are nonempty
    mask = 4'b0010;
    push_word(0, 8'h30);
    push_word(0, 8'h31);
    push_word(1, 8'h40);
    push_word(1, 8'h41);
    expect_word(1, 8'h40, 1'b0);
    expect_word(1, 8'h41, 1'b0);
    for (int i = 0; i < 8; i++) cycle();
    chk("mask_ch1_done", 32'(sb.size()), 32'(0));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mask_ch0_blocked_busy",  32'(s_busy),  32'(1'b0));
      chk("mask_ch0_blocked_valid", 32'(s_valid), 32'(1'b0));
    end
    chk("mask_ch0_untouched", 32'(qsize(0)), 32'(2));
    // Enabling channel 0 lets it in; dropping its mask mid-burst does not cut it off
    mask = 4'hF;
    expect_word(0, 8'h30, 1'b0);
    expect_word(0, 8'h31, 1'b0);
    cycle();
    cycle();
    mask = 4'h0;
    run_until(20, "mask");
    mask = 4'hF;

    // Reset mid-burst from FIFO2
    for (int i = 0; i < 6; i++) push_word(2, 8'(8'h50 + i));
    expect_word(2, 8'h50, 1'b0);
    expect_word(2, 8'h51, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("rst_mid_pre_valid", 32'(sif.valid_o), 32'(1'b1));
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    cycle();
    rst = 1'b0;
    chk("rst_mid_no_replay", 32'(qsize(2)), 32'(4));
    push_word(0, 8'h60);
    push_word(0, 8'h61);
    expect_word(0, 8'h60, 1'b0);
    expect_word(0, 8'h61, 1'b0);
    for (int i = 0; i < 4; i++) expect_word(2, 8'(8'h52 + i), (i == 3));
    run_until(40, "rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo_rr_scheduler
